// File: rtl/perf_counter_unit_if.sv
// Event inputs and counter outputs of perf_counter_unit, grouped as one bundle.
// The profiled core side drives through master; the counter unit sits on slave.
interface perf_counter_unit_if #(
    parameter int NUM_WARPS     = 8,
    parameter int COUNTER_WIDTH = 64,
    parameter int RETIRE_WIDTH  = 4
);
    logic                               start;
    logic                               done;
    logic                               clear;
    logic [RETIRE_WIDTH-1:0]            retire_count;
    logic                               eligible;
    logic                               issued;
    logic [NUM_WARPS-1:0]               warp_decoded;
    logic [NUM_WARPS-1:0]               warp_stall_waw;
    logic [NUM_WARPS-1:0]               warp_stall_war;

    logic                               finished;
    logic [COUNTER_WIDTH-1:0]           instRetired;
    logic [COUNTER_WIDTH-1:0]           cycles;
    logic [COUNTER_WIDTH-1:0]           cyclesDecoded;
    logic [COUNTER_WIDTH-1:0]           cyclesEligible;
    logic [COUNTER_WIDTH-1:0]           cyclesIssued;
    logic [NUM_WARPS*COUNTER_WIDTH-1:0] perWarp_cyclesDecoded;
    logic [NUM_WARPS*COUNTER_WIDTH-1:0] perWarp_stallsWAW;
    logic [NUM_WARPS*COUNTER_WIDTH-1:0] perWarp_stallsWAR;

    modport master (
        output start, done, clear, retire_count, eligible, issued,
               warp_decoded, warp_stall_waw, warp_stall_war,
        input  finished, instRetired, cycles, cyclesDecoded, cyclesEligible,
               cyclesIssued, perWarp_cyclesDecoded, perWarp_stallsWAW, perWarp_stallsWAR
    );

    modport slave (
        input  start, done, clear, retire_count, eligible, issued,
               warp_decoded, warp_stall_waw, warp_stall_war,
        output finished, instRetired, cycles, cyclesDecoded, cyclesEligible,
               cyclesIssued, perWarp_cyclesDecoded, perWarp_stallsWAW, perWarp_stallsWAR
    );
endinterface

// File: rtl/perf_counter_unit.sv
// Saturating performance counters for one profiling run (IDLE -> RUN -> DONE).
// All outputs come straight from registers; events count only while in RUN.
module perf_counter_unit #(
    parameter int NUM_WARPS     = 8,
    parameter int COUNTER_WIDTH = 64,
    parameter int RETIRE_WIDTH  = 4
) (
    input logic                clock,
    input logic                reset,
    perf_counter_unit_if.slave bus
);
    localparam int CW = COUNTER_WIDTH;
    localparam int RW = RETIRE_WIDTH;
    localparam int SW = ((CW > RW) ? CW : RW) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] acc, input logic [RW-1:0] inc);
        logic [SW-1:0] sum;
        logic [CW-1:0] res;
        sum = SW'(acc) + SW'(inc);
        if (sum > SW'({CW{1'b1}}))
            res = {CW{1'b1}};
        else
            res = sum[CW-1:0];
        return res;
    endfunction

    logic [1:0]    state_p0;
    logic          fin_p0;
    logic          vld_p0;
    logic [CW-1:0] inst_p0;
    logic [CW-1:0] cyc_p0;
    logic [CW-1:0] cdec_p0;
    logic [CW-1:0] celig_p0;
    logic [CW-1:0] ciss_p0;
    logic [CW-1:0] wdec_p0 [NUM_WARPS];
    logic [CW-1:0] wwaw_p0 [NUM_WARPS];
    logic [CW-1:0] wwar_p0 [NUM_WARPS];

    assign vld_p0 = (state_p0 == RUN);

    // Stage p0: state and counters; reset and clear have the same effect
    always_ff @(posedge clock) begin
        if (reset || bus.clear) begin
            state_p0 <= IDLE;
            fin_p0   <= 1'b0;
            inst_p0  <= '0;
            cyc_p0   <= '0;
            cdec_p0  <= '0;
            celig_p0 <= '0;
            ciss_p0  <= '0;
            for (int i = 0; i < NUM_WARPS; i++) begin
                wdec_p0[i] <= '0;
                wwaw_p0[i] <= '0;
                wwar_p0[i] <= '0;
            end
        end else begin
            case (state_p0)
                IDLE: if (bus.start) state_p0 <= RUN;
                RUN: begin
                    if (bus.done) begin
                        state_p0 <= DONE;
                        fin_p0   <= 1'b1;
                    end
                end
                default: ;
            endcase

            // Counting is gated on RUN so unknown inputs elsewhere never reach the counters
            if (vld_p0) begin
                cyc_p0   <= sat_add(cyc_p0, RW'(1'b1));
                inst_p0  <= sat_add(inst_p0, bus.retire_count);
                cdec_p0  <= sat_add(cdec_p0, RW'(|bus.warp_decoded));
                celig_p0 <= sat_add(celig_p0, RW'(bus.eligible));
                ciss_p0  <= sat_add(ciss_p0, RW'(bus.issued));
                for (int i = 0; i < NUM_WARPS; i++) begin
                    wdec_p0[i] <= sat_add(wdec_p0[i], RW'(bus.warp_decoded[i]));
                    wwaw_p0[i] <= sat_add(wwaw_p0[i], RW'(bus.warp_stall_waw[i]));
                    wwar_p0[i] <= sat_add(wwar_p0[i], RW'(bus.warp_stall_war[i]));
                end
            end
        end
    end

    assign bus.finished       = fin_p0;
    assign bus.instRetired    = inst_p0;
    assign bus.cycles         = cyc_p0;
    assign bus.cyclesDecoded  = cdec_p0;
    assign bus.cyclesEligible = celig_p0;
    assign bus.cyclesIssued   = ciss_p0;

    for (genvar g = 0; g < NUM_WARPS; g++) begin : g_pack
        assign bus.perWarp_cyclesDecoded[g*CW +: CW] = wdec_p0[g];
        assign bus.perWarp_stallsWAW[g*CW +: CW]     = wwaw_p0[g];
        assign bus.perWarp_stallsWAR[g*CW +: CW]     = wwar_p0[g];
    end
endmodule

// File: tb/tb_perf_counter_unit.sv
// Directed vector bench for perf_counter_unit: default-width instance plus a
// 4-bit-counter instance for saturation.
module tb_perf_counter_unit;
    logic clock;
    logic rst;
    logic rst_s;

    perf_counter_unit_if #(.NUM_WARPS(8), .COUNTER_WIDTH(64), .RETIRE_WIDTH(4)) bus ();
    perf_counter_unit_if #(.NUM_WARPS(8), .COUNTER_WIDTH(4),  .RETIRE_WIDTH(4)) sbus ();

    perf_counter_unit #(.NUM_WARPS(8), .COUNTER_WIDTH(64), .RETIRE_WIDTH(4)) dut (
        .clock (clock),
        .reset (rst),
        .bus   (bus.slave)
    );

    perf_counter_unit #(.NUM_WARPS(8), .COUNTER_WIDTH(4), .RETIRE_WIDTH(4)) dut_sat (
        .clock (clock),
        .reset (rst_s),
        .bus   (sbus.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic        rst, start, done, clear;
        logic [3:0]  retire;
        logic        elig, iss;
        logic [7:0]  dec, waw, war;
        logic [31:0] e_cyc, e_inst, e_dec, e_elig, e_iss;
        logic        e_fin;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic r, input logic st, input logic dn, input logic cl,
                                input logic [3:0] rc, input logic el, input logic is,
                                input logic [7:0] dc, input logic [7:0] ww, input logic [7:0] wr,
                                input int c, input int ir, input int cd, input int ce,
                                input int ci, input logic f);
        vec_t v;
        v.rst = r; v.start = st; v.done = dn; v.clear = cl;
        v.retire = rc; v.elig = el; v.iss = is;
        v.dec = dc; v.waw = ww; v.war = wr;
        v.e_cyc = c; v.e_inst = ir; v.e_dec = cd; v.e_elig = ce; v.e_iss = ci;
        v.e_fin = f;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            rst                = tbl[i].rst;
            bus.start          = tbl[i].start;
            bus.done           = tbl[i].done;
            bus.clear          = tbl[i].clear;
            bus.retire_count   = tbl[i].retire;
            bus.eligible       = tbl[i].elig;
            bus.issued         = tbl[i].iss;
            bus.warp_decoded   = tbl[i].dec;
            bus.warp_stall_waw = tbl[i].waw;
            bus.warp_stall_war = tbl[i].war;
            @(posedge clock);
            #1;
            chk($sformatf("v%0d.cycles", i),         bus.cycles,         64'(tbl[i].e_cyc));
            chk($sformatf("v%0d.instRetired", i),    bus.instRetired,    64'(tbl[i].e_inst));
            chk($sformatf("v%0d.cyclesDecoded", i),  bus.cyclesDecoded,  64'(tbl[i].e_dec));
            chk($sformatf("v%0d.cyclesEligible", i), bus.cyclesEligible, 64'(tbl[i].e_elig));
            chk($sformatf("v%0d.cyclesIssued", i),   bus.cyclesIssued,   64'(tbl[i].e_iss));
            chk($sformatf("v%0d.finished", i),       64'(bus.finished),  64'(tbl[i].e_fin));
        end
    endtask

    task automatic sat_step(input logic st, input logic dn, input logic [3:0] rc, input logic [7:0] dc);
        sbus.start        = st;
        sbus.done         = dn;
        sbus.retire_count = rc;
        sbus.warp_decoded = dc;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [7:0] waw_m;
        logic [7:0] war_m;

        rst_s = 1'b1;
        sbus.start = 1'b0; sbus.done = 1'b0; sbus.clear = 1'b0;
        sbus.retire_count = '0; sbus.eligible = 1'b0; sbus.issued = 1'b0;
        sbus.warp_decoded = '0; sbus.warp_stall_waw = '0; sbus.warp_stall_war = '0;

        // rst st dn cl  ret el is  dec    waw    war  | cyc inst dec elig iss fin
        tbl.push_back(mk(1,0,0,0, 4'd0,0,0, 8'h00,8'h00,8'h00,  0, 0, 0, 0, 0, 0)); // 0 reset
        tbl.push_back(mk(0,0,0,0, 4'd5,1,1, 8'hFF,8'hFF,8'hFF,  0, 0, 0, 0, 0, 0)); // 1 IDLE activity
        tbl.push_back(mk(0,0,1,0, 4'bx,1'bx,1'bx, 8'hxx,8'hxx,8'hxx, 0,0,0,0,0,0)); // 2 X + done in IDLE
        tbl.push_back(mk(0,1,0,0, 4'd2,1,1, 8'h01,8'h00,8'h00,  0, 0, 0, 0, 0, 0)); // 3 start cycle
        tbl.push_back(mk(0,0,0,0, 4'd2,1,1, 8'h01,8'h00,8'h00,  1, 2, 1, 1, 1, 0)); // 4 run k=1
        tbl.push_back(mk(0,0,0,0, 4'd2,1,0, 8'h01,8'h00,8'h00,  2, 4, 2, 2, 1, 0));
        tbl.push_back(mk(0,0,0,0, 4'd2,1,1, 8'h01,8'h00,8'h00,  3, 6, 3, 3, 2, 0));
        tbl.push_back(mk(0,0,0,0, 4'd2,1,0, 8'h01,8'h00,8'h00,  4, 8, 4, 4, 2, 0));
        tbl.push_back(mk(0,0,0,0, 4'd2,1,1, 8'h01,8'h00,8'h00,  5,10, 5, 5, 3, 0));
        tbl.push_back(mk(0,0,0,0, 4'd2,1,0, 8'h01,8'h00,8'h00,  6,12, 6, 6, 3, 0));
        tbl.push_back(mk(0,0,0,0, 4'd2,1,1, 8'h01,8'h00,8'h00,  7,14, 7, 7, 4, 0));
        tbl.push_back(mk(0,0,0,0, 4'd2,1,0, 8'h01,8'h00,8'h00,  8,16, 8, 8, 4, 0));
        tbl.push_back(mk(0,0,0,0, 4'd2,1,1, 8'h01,8'h00,8'h00,  9,18, 9, 9, 5, 0));
        tbl.push_back(mk(0,0,1,0, 4'd2,1,0, 8'h01,8'h00,8'h00, 10,20,10,10, 5, 1)); // 13 done
        tbl.push_back(mk(0,1,0,0, 4'd7,1,1, 8'hFF,8'hFF,8'hFF, 10,20,10,10, 5, 1)); // 14 frozen
        tbl.push_back(mk(0,0,0,0, 4'd7,1,1, 8'hFF,8'hFF,8'hFF, 10,20,10,10, 5, 1));
        tbl.push_back(mk(0,0,1,0, 4'd7,1,1, 8'hFF,8'hFF,8'hFF, 10,20,10,10, 5, 1));
        tbl.push_back(mk(0,1,0,0, 4'd7,1,1, 8'hFF,8'hFF,8'hFF, 10,20,10,10, 5, 1));
        tbl.push_back(mk(0,0,0,0, 4'd7,1,1, 8'hFF,8'hFF,8'hFF, 10,20,10,10, 5, 1)); // 18
        tbl.push_back(mk(0,1,0,1, 4'd7,1,1, 8'hFF,8'hFF,8'hFF,  0, 0, 0, 0, 0, 0)); // 19 clear beats start
        tbl.push_back(mk(0,0,0,0, 4'd7,1,1, 8'hFF,8'hFF,8'hFF,  0, 0, 0, 0, 0, 0)); // 20 back in IDLE
        tbl.push_back(mk(0,1,1,0, 4'd7,1,1, 8'hFF,8'hFF,8'hFF,  0, 0, 0, 0, 0, 0)); // 21 start+done
        tbl.push_back(mk(0,0,0,0, 4'd1,0,1, 8'h00,8'h00,8'h00,  1, 1, 0, 0, 1, 0)); // 22 counting => RUN
        tbl.push_back(mk(0,0,0,0, 4'd0,0,0, 8'h00,8'hA5,8'h0F,  2, 1, 0, 0, 1, 0)); // 23 stalls
        tbl.push_back(mk(0,0,0,0, 4'd0,0,0, 8'h00,8'hA5,8'h0F,  3, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0,0,0,0, 4'd0,0,0, 8'h00,8'hA5,8'h0F,  4, 1, 0, 0, 1, 0)); // 25
        tbl.push_back(mk(0,0,0,0, 4'd0,0,0, 8'h02,8'h00,8'h00,  5, 1, 1, 0, 1, 0)); // 26
        tbl.push_back(mk(0,0,0,0, 4'd0,0,0, 8'h02,8'h00,8'h00,  6, 1, 2, 0, 1, 0));
        tbl.push_back(mk(0,0,0,0, 4'd0,0,0, 8'h02,8'h00,8'h00,  7, 1, 3, 0, 1, 0)); // 28
        tbl.push_back(mk(1,1,1,0, 4'd9,1,1, 8'hFF,8'hFF,8'hFF,  0, 0, 0, 0, 0, 0)); // 29 reset mid-run
        tbl.push_back(mk(0,1,0,0, 4'd9,1,1, 8'hFF,8'h00,8'h00,  0, 0, 0, 0, 0, 0)); // 30 restart
        tbl.push_back(mk(0,0,0,0, 4'd3,1,0, 8'h00,8'h00,8'h00,  1, 3, 0, 1, 0, 0));
        tbl.push_back(mk(0,0,1,0, 4'd0,0,0, 8'h00,8'h00,8'h00,  2, 3, 0, 1, 0, 1)); // 32

        apply(0, 13);
        chk("basic.warp0_dec", bus.perWarp_cyclesDecoded[0*64 +: 64], 64'd10);
        chk("basic.warp1_dec", bus.perWarp_cyclesDecoded[1*64 +: 64], 64'd0);
        chk("basic.warp7_dec", bus.perWarp_cyclesDecoded[7*64 +: 64], 64'd0);

        apply(14, 25);
        waw_m = 8'hA5;
        war_m = 8'h0F;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("stall.waw%0d", i), bus.perWarp_stallsWAW[i*64 +: 64], waw_m[i] ? 64'd3 : 64'd0);
            chk($sformatf("stall.war%0d", i), bus.perWarp_stallsWAR[i*64 +: 64], war_m[i] ? 64'd3 : 64'd0);
        end

        apply(26, 28);
        chk("run.warp1_dec", bus.perWarp_cyclesDecoded[1*64 +: 64], 64'd3);
        apply(29, 29);
        chk("rst.warp1_dec", bus.perWarp_cyclesDecoded[1*64 +: 64], 64'd0);
        chk("rst.warp0_waw", bus.perWarp_stallsWAW[0*64 +: 64], 64'd0);
        chk("rst.warp0_war", bus.perWarp_stallsWAR[0*64 +: 64], 64'd0);
        apply(30, 32);

        // Saturation on the 4-bit counter instance
        bus.start = 1'b0; bus.done = 1'b0; bus.clear = 1'b0;
        sat_step(0, 0, 4'd0, 8'h00);
        rst_s = 1'b0;
        sat_step(1, 0, 4'd3, 8'hFF);
        chk("sat.start_cycles", 64'(sbus.cycles), 64'd0);
        for (int k = 1; k <= 20; k++) begin
            sat_step(0, 0, 4'd3, 8'hFF);
            if (k == 5) begin
                chk("sat.k5_cycles", 64'(sbus.cycles), 64'd5);
                chk("sat.k5_inst",   64'(sbus.instRetired), 64'd15);
            end
            if (k == 15) chk("sat.k15_cycles", 64'(sbus.cycles), 64'd15);
        end
        chk("sat.cycles",    64'(sbus.cycles), 64'd15);
        chk("sat.inst",      64'(sbus.instRetired), 64'd15);
        chk("sat.dec",       64'(sbus.cyclesDecoded), 64'd15);
        chk("sat.warp7_dec", 64'(sbus.perWarp_cyclesDecoded[7*4 +: 4]), 64'd15);
        sat_step(0, 1, 4'd0, 8'h00);
        chk("sat.finished",  64'(sbus.finished), 64'd1);
        chk("sat.final_cyc", 64'(sbus.cycles), 64'd15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
